gesture_packet_tx: RTL and testbench
====================================

# gesture_packet_tx

Serial packet transmitter for gesture-recognition results. It latches a fixed-length multi-byte word (centre_x, centre_y, gesture number, terminator) when the result-ready flag rises, then shifts it out as 8N1 UART frames on `tx`. It sits downstream of the image-process result outputs (`centre_x`, `centre_y`, `data`, `end_flag`) and drives the board UART pin in the `clk_24m` domain.

## Interface
Parameters:
- `CLK_FREQ`, 24_000_000: input clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `BYTE_NUM`, 6: bytes per packet. Data width is `BYTE_NUM*8`.

Ports:
- `clk`  in  1  system clock (24 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `pi_data`  in  `BYTE_NUM*8`  packet payload. Transmitted byte order is `[MSB byte … LSB byte]`.
- `pi_flag`  in  1  result-ready flag. Only its rising edge is used.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high while a packet is in flight.
- `done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- `BAUD_DIV = CLK_FREQ/BAUD`, integer-truncated; at the defaults it is 208. Each bit lasts exactly `BAUD_DIV` clk cycles.
- Edge detect: `pi_flag` is registered once. A trigger is `pi_flag & ~pi_flag_d`. A level held high triggers exactly once.
- FSM states:
  - **IDLE**: `tx=1`, `busy=0`. On a trigger, latch `pi_data` into the shift register, clear the byte and bit counters, then go to START.
  - **START**: `tx=0` for `BAUD_DIV` cycles, then go to DATA.
  - **DATA**: 8 bits, LSB first, taken from the current byte. Each bit is held `BAUD_DIV` cycles. After bit 7, go to STOP.
  - **STOP**: `tx=1` for `BAUD_DIV` cycles. Then:
    - if `byte_cnt < BYTE_NUM-1`: increment `byte_cnt` and go to START, with no idle gap;
    - otherwise go to IDLE and pulse `done`.
- Byte k (k = 0…`BYTE_NUM-1`) sent is `latched[(BYTE_NUM-1-k)*8 +: 8]`.
- Triggers while `busy=1` are ignored and not queued. `pi_data` changes after the latch have no effect on the packet in flight.
- Counters:
  - baud counter is 0…`BAUD_DIV-1` and wraps to 0 at each bit boundary;
  - bit counter is 3 bits;
  - byte counter is `$clog2(BYTE_NUM)` bits.
- `tx` is driven from a register with no combinational path to the output.

## Timing
- Reset values: `tx=1`, `busy=0`, `done=0`, FSM=IDLE, all counters 0, shift register 0.
- Reset mid-packet: `tx` returns to 1 and `busy` to 0 asynchronously. No partial frame resumes after release.
- Latency: if `pi_flag` rises, sampled at edge N, then:
  - trigger is detected at edge N+1;
  - `tx` falls and `busy` rises after edge N+2.
- Packet length: `BYTE_NUM*10*BAUD_DIV` cycles from the start-bit fall to the end of the last stop bit. At defaults this is 12480 cycles (about 520 µs).
- End of packet: `done=1` and `busy=0` in the same cycle, the first cycle after the last stop bit.
- Back-to-back: a trigger detected in the `done` cycle is accepted, because `busy` is already 0. The next start bit follows the last stop bit with at most 2 cycles of idle high.

## Test plan
- **Reset**: assert `rst_n=0` mid-DATA of byte 2 -> `tx=1`, `busy=0` immediately. After release, `tx` stays 1 with no activity until a new `pi_flag` edge.
- **Nominal packet**: `pi_data=48'h012C_00F0_050A` (cx=300, cy=240, num=5), `pi_flag` pulsed one cycle. Required response:
  - line decodes to 0x01, 0x2C, 0x00, 0xF0, 0x05, 0x0A;
  - every bit is exactly 208 cycles;
  - `done` pulses once, 12480 cycles after the `tx` fall.
- **Level hold**: hold `pi_flag=1` for 30000 cycles with `pi_data=48'hFFFF_FFFF_FFFF` -> exactly one packet of 0xFF bytes. `busy` falls at cycle 12480 and stays low.
- **Busy ignore**: send a new `pi_flag` edge with `pi_data=48'h0` at cycle 5000 of a packet of `48'hA5A5_A5A5_A5A5` -> all six bytes decode as 0xA5 and no second packet follows.
- **Back-to-back**: raise a new `pi_flag` edge in the `done` cycle with `pi_data=48'h0102_0304_0506` -> second packet 01 02 03 04 05 06 starts within 2 cycles of the end of the first stop bit.
- **Parameter check**: `CLK_FREQ=24_000_000`, `BAUD=9600`, `BYTE_NUM=2`, `pi_data=16'h5A0A` -> bit time 2500 cycles, bytes 0x5A then 0x0A, `done` 50000 cycles after the start-bit fall.

Source files
------------

// File: rtl/gesture_packet_tx.sv
// Gesture result packet transmitter: on a rising result flag, latches a BYTE_NUM-byte
// word and sends it MSB byte first as back-to-back 8N1 UART frames.
module gesture_packet_tx #(
    parameter int CLK_FREQ = 24_000_000,
    parameter int BAUD     = 115200,
    parameter int BYTE_NUM = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BYTE_NUM*8-1:0] pi_data,
    input  logic                  pi_flag,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BDW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BCW      = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
    localparam int W        = BYTE_NUM * 8;

    localparam logic [BDW-1:0] BAUD_LAST = BDW'(BAUD_DIV - 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(BYTE_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         state_q;
    logic [BDW-1:0] baud_cnt_q;
    logic [2:0]     bit_cnt_q;
    logic [BCW-1:0] byte_cnt_q;
    logic [W-1:0]   shift_q;
    logic           pi_flag_q;
    logic           last_q;
    logic           tx_q;
    logic           busy_q;
    logic           done_q;

    logic           trigger;
    logic           bit_end;
    logic [7:0]     cur_byte;

    assign trigger  = pi_flag & ~pi_flag_q;
    assign bit_end  = (baud_cnt_q == BAUD_LAST);
    assign cur_byte = shift_q[W-1 -: 8];

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // Outputs are registered from the current state, so the line, busy and done all
    // trail the FSM by one cycle; bit widths are unaffected because the lag is uniform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            pi_flag_q  <= 1'b0;
            last_q     <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register below see the
            // pre-edge value of state_q and the counters, regardless of statement order.
            pi_flag_q <= pi_flag;
            last_q    <= 1'b0;
            done_q    <= last_q;
            busy_q    <= (state_q != S_IDLE);

            case (state_q)
                S_START: tx_q <= 1'b0;
                S_DATA:  tx_q <= cur_byte[bit_cnt_q];
                default: tx_q <= 1'b1;
            endcase

            if (state_q != S_IDLE) begin
                baud_cnt_q <= bit_end ? '0 : baud_cnt_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        shift_q    <= pi_data;
                        byte_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        baud_cnt_q <= '0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        // Next byte follows straight after the stop bit, no idle gap.
                        if (byte_cnt_q < BYTE_LAST) begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            shift_q    <= shift_q << 8;
                            state_q    <= S_START;
                        end else begin
                            last_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_packet_tx.sv
// Self-checking bench for gesture_packet_tx: line decoders feed a byte scoreboard,
// a vector table drives the packet scenarios, hand sequences cover reset and timing.
module tb_gesture_packet_tx;

    localparam int BIT0 = 208;
    localparam int PKT0 = 12480;
    localparam int BIT1 = 2500;
    localparam int PKT1 = 50000;

    typedef enum int {M_PULSE, M_B2B, M_BUSY, M_LEVEL} mode_t;

    typedef struct {
        logic [47:0] data;
        mode_t       mode;
        logic [7:0]  exp [6];
    } vec_t;

    vec_t vecs [4];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst1_n;
    logic [47:0] pi_data0;
    logic        pi_flag0;
    logic [15:0] pi_data1;
    logic        pi_flag1;
    logic        tx0, busy0, done0;
    logic        tx1, busy1, done1;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   ignore0 = 1'b0;
    bit   p1_done = 1'b0;

    logic [7:0] exp0_q [$];
    logic [7:0] exp1_q [$];

    gesture_packet_tx u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .pi_data (pi_data0),
        .pi_flag (pi_flag0),
        .tx      (tx0),
        .busy    (busy0),
        .done    (done0)
    );

    gesture_packet_tx #(
        .CLK_FREQ (24_000_000),
        .BAUD     (9600),
        .BYTE_NUM (2)
    ) u_dut1 (
        .clk     (clk),
        .rst_n   (rst1_n),
        .pi_data (pi_data1),
        .pi_flag (pi_flag1),
        .tx      (tx1),
        .busy    (busy1),
        .done    (done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called on the first low cycle of a start bit; samples every cycle of all ten bits
    // and flags any bit that is not constant for exactly bitc cycles.
    task automatic decode_frame(input int bitc, input bit sel, output logic [7:0] b, output bit ok);
        logic v;
        logic first;
        ok = 1'b1;
        b  = '0;
        first = 1'b1;
        for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < bitc; c++) begin
                if (!(bi == 0 && c == 0)) @(negedge clk);
                v = sel ? tx1 : tx0;
                if (c == 0) first = v;
                else if (v !== first) ok = 1'b0;
            end
            if (bi == 0 && first !== 1'b0) ok = 1'b0;
            if (bi == 9 && first !== 1'b1) ok = 1'b0;
            if (bi >= 1 && bi <= 8) b[bi-1] = first;
        end
    endtask

    task automatic score(input bit sel, input logic [7:0] b, input bit ok);
        logic [7:0] e;
        int n;
        n = sel ? exp1_q.size() : exp0_q.size();
        check(sel ? "dut1_frame_expected" : "dut0_frame_expected", 64'(n > 0), 64'd1);
        if (n > 0) begin
            if (sel) e = exp1_q.pop_front();
            else     e = exp0_q.pop_front();
            check(sel ? "dut1_byte" : "dut0_byte", 64'(b), 64'(e));
            check(sel ? "dut1_framing" : "dut0_framing", 64'(ok), 64'd1);
        end
    endtask

    initial begin : dec0
        logic prev;
        logic [7:0] b;
        bit ok;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx0 === 1'b0) begin
                decode_frame(BIT0, 1'b0, b, ok);
                if (!ignore0) score(1'b0, b, ok);
            end
            prev = tx0;
        end
    end

    initial begin : dec1
        logic prev;
        logic [7:0] b;
        bit ok;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx1 === 1'b0) begin
                decode_frame(BIT1, 1'b1, b, ok);
                score(1'b1, b, ok);
            end
            prev = tx1;
        end
    end

    task automatic launch0(input logic [47:0] d, input bit hold, input bit lat, output int fall);
        fall = -1;
        @(posedge clk); #1;
        pi_data0 = d;
        pi_flag0 = 1'b1;
        @(posedge clk); #1;
        if (!hold) pi_flag0 = 1'b0;
        if (lat) begin
            @(negedge clk);
            check("lat_e1_tx", 64'(tx0), 64'd1);
            check("lat_e1_busy", 64'(busy0), 64'd0);
            @(negedge clk);
            check("lat_e2_tx", 64'(tx0), 64'd0);
            check("lat_e2_busy", 64'(busy0), 64'd1);
            fall = cyc;
        end
    endtask

    task automatic wait_done0(input int max, output bit seen, output int dcyc);
        seen = 1'b0;
        dcyc = 0;
        for (int k = 0; k < max && !seen; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
    endtask

    initial begin : param_run
        int  f1, d1;
        bit  found;
        pi_data1 = '0;
        pi_flag1 = 1'b0;
        rst1_n   = 1'b1;
        #2 rst1_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst1_n = 1'b1;
        exp1_q.push_back(8'h5A);
        exp1_q.push_back(8'h0A);
        @(posedge clk); #1;
        pi_data1 = 16'h5A0A;
        pi_flag1 = 1'b1;
        @(posedge clk); #1;
        pi_flag1 = 1'b0;
        found = 1'b0;
        f1 = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (tx1 === 1'b0) begin
                found = 1'b1;
                f1 = cyc;
            end
        end
        check("dut1_fall_seen", 64'(found), 64'd1);
        found = 1'b0;
        d1 = 0;
        for (int k = 0; k < PKT1 + 100 && !found; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                found = 1'b1;
                d1 = cyc;
            end
        end
        check("dut1_done_seen", 64'(found), 64'd1);
        check("dut1_pkt_len", 64'(d1 - f1), 64'(PKT1));
        check("dut1_done_busy_low", 64'(busy1), 64'd0);
        p1_done = 1'b1;
    end

    initial begin : main
        int  f, dc, fcyc, ls, dummy;
        bit  seen, quiet, found, next_b2b;

        vecs[0].data = 48'h012C_00F0_050A; vecs[0].mode = M_PULSE;
        vecs[0].exp  = '{8'h01, 8'h2C, 8'h00, 8'hF0, 8'h05, 8'h0A};
        vecs[1].data = 48'h0102_0304_0506; vecs[1].mode = M_B2B;
        vecs[1].exp  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        vecs[2].data = 48'hA5A5_A5A5_A5A5; vecs[2].mode = M_BUSY;
        vecs[2].exp  = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        vecs[3].data = 48'hFFFF_FFFF_FFFF; vecs[3].mode = M_LEVEL;
        vecs[3].exp  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        pi_data0 = '0;
        pi_flag0 = 1'b0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 64'(tx0), 64'd1);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        rst_n = 1'b1;

        // Reset asserted in the middle of byte 2's data bits.
        ignore0 = 1'b1;
        launch0(48'h1122_3344_5566, 1'b0, 1'b1, f);
        while (cyc < f + 2 * 10 * BIT0 + 4 * BIT0) @(negedge clk);
        check("pre_rst_tx_low", 64'(tx0), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", 64'(tx0), 64'd1);
        check("async_rst_busy", 64'(busy0), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (2500) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
        end
        check("rst_release_quiet", 64'(quiet), 64'd1);
        ignore0 = 1'b0;

        f = -1;
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].mode != M_B2B) begin
                ls = cyc;
                for (int k = 0; k < 6; k++) exp0_q.push_back(vecs[i].exp[k]);
                launch0(vecs[i].data, vecs[i].mode == M_LEVEL, 1'b1, f);
            end

            if (vecs[i].mode == M_BUSY) begin
                while (cyc < f + 5000) @(negedge clk);
                launch0(48'h0, 1'b0, 1'b0, dummy);
                @(negedge clk);
                check("busy_inject_busy", 64'(busy0), 64'd1);
            end

            wait_done0(PKT0 + 100, seen, dc);
            check("done_seen", 64'(seen), 64'd1);
            check("pkt_len", 64'(dc - f), 64'(PKT0));
            check("done_busy_low", 64'(busy0), 64'd0);

            next_b2b = 1'b0;
            if (i < 3) next_b2b = (vecs[i+1].mode == M_B2B);
            if (next_b2b) begin
                for (int k = 0; k < 6; k++) exp0_q.push_back(vecs[i+1].exp[k]);
                pi_data0 = vecs[i+1].data;
                pi_flag0 = 1'b1;
            end
            @(negedge clk);
            check("done_one_cycle", 64'(done0), 64'd0);

            if (next_b2b) begin
                pi_flag0 = 1'b0;
                found = 1'b0;
                fcyc = 0;
                for (int k = 0; k < 10 && !found; k++) begin
                    if (tx0 === 1'b0) begin
                        found = 1'b1;
                        fcyc = cyc;
                    end else begin
                        @(negedge clk);
                    end
                end
                check("b2b_fall_seen", 64'(found), 64'd1);
                check("b2b_gap_le2", 64'((fcyc - dc) <= 2), 64'd1);
                f = fcyc;
            end

            if (vecs[i].mode == M_BUSY) begin
                quiet = 1'b1;
                repeat (1000) begin
                    @(negedge clk);
                    if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
                end
                check("busy_no_second_pkt", 64'(quiet), 64'd1);
            end

            if (vecs[i].mode == M_LEVEL) begin
                quiet = 1'b1;
                while (cyc < ls + 30000) begin
                    @(negedge clk);
                    if (tx0 !== 1'b1 || busy0 !== 1'b0) quiet = 1'b0;
                end
                check("level_single_pkt", 64'(quiet), 64'd1);
                check("level_flag_held", 64'(pi_flag0), 64'd1);
                pi_flag0 = 1'b0;
            end
        end

        for (int k = 0; k < PKT1 + 1000 && !p1_done; k++) @(negedge clk);
        check("dut1_finished", 64'(p1_done), 64'd1);
        check("dut0_queue_empty", 64'(exp0_q.size()), 64'd0);
        check("dut1_queue_empty", 64'(exp1_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
